// File: rtl/ad_ip_jesd204_tpl_adc_sync_pkg.sv
// Shared types and constants for the TPL ADC capture-start sequencer.
package ad_ip_jesd204_tpl_adc_sync_pkg;

  localparam int SYNC_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    WAIT_SOF = 2'd2,
    PULSE    = 2'd3
  } sync_state_t;

  // Minimum counter width able to hold max_value (never below one bit).
  function automatic int timer_width(input int max_value);
    return (max_value <= 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_sync_timer.sv
// Loadable down-counter; terminal flags the last counted cycle (value one).
module ad_ip_jesd204_tpl_adc_sync_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             terminal
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Load has priority over decrement; the counter rests at zero.
  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign terminal = (count_reg == WIDTH'(1));

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_sync_ctrl.sv
// Arms on request, waits for a SYNC edge / manual trigger, aligns the core
// sync reset to a frame start and gates DMA valid until the pulse completes.
module ad_ip_jesd204_tpl_adc_sync_ctrl
  import ad_ip_jesd204_tpl_adc_sync_pkg::*;
#(
  parameter int EXT_SYNC        = 0,
  parameter int OCTETS_PER_BEAT = 4,
  parameter int ALIGN_TO_SOF    = 1,
  parameter int RST_CYCLES      = 4,
  parameter int TIMEOUT_WIDTH   = 24,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        arm,
  input  logic                        disarm,
  input  logic                        soft_sync,
  input  logic                        manual_req,
  input  logic                        sync_in,
  input  logic                        link_valid,
  input  logic [OCTETS_PER_BEAT-1:0]  link_sof,
  output logic                        adc_rst_sync,
  output logic                        sync_status,
  output logic                        data_enable,
  output logic                        timeout,
  output logic [SYNC_COUNT_WIDTH-1:0] sync_count
);

  localparam int PULSE_WIDTH = timer_width(RST_CYCLES);
  localparam logic [PULSE_WIDTH-1:0] PULSE_LOAD = PULSE_WIDTH'(RST_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LOAD = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic EXT_SYNC_EN = (EXT_SYNC != 0);
  localparam logic ALIGN_EN    = (ALIGN_TO_SOF != 0);

  sync_state_t                 state_reg, state_next;
  logic                        sync_in_d_reg;
  logic                        adc_rst_sync_reg, adc_rst_sync_next;
  logic                        sync_status_reg, sync_status_next;
  logic                        data_enable_reg, data_enable_next;
  logic                        timeout_reg, timeout_next;
  logic [SYNC_COUNT_WIDTH-1:0] sync_count_reg, sync_count_next;

  logic timeout_load, timeout_dec, timeout_terminal;
  logic pulse_load, pulse_dec, pulse_terminal;
  logic trig_ext, trigger, sof_beat;

  // A level that is already high when we arm never counts as an edge.
  assign trig_ext = EXT_SYNC_EN & sync_in & ~sync_in_d_reg;
  assign trigger  = trig_ext | manual_req | soft_sync;
  assign sof_beat = ALIGN_EN ? (link_valid & (|link_sof)) : 1'b1;

  ad_ip_jesd204_tpl_adc_sync_timer #(
    .WIDTH (TIMEOUT_WIDTH)
  ) i_armed_timer (
    .clk        (clk),
    .resetn     (resetn),
    .load       (timeout_load),
    .load_value (TIMEOUT_LOAD),
    .dec        (timeout_dec),
    .terminal   (timeout_terminal)
  );

  ad_ip_jesd204_tpl_adc_sync_timer #(
    .WIDTH (PULSE_WIDTH)
  ) i_pulse_timer (
    .clk        (clk),
    .resetn     (resetn),
    .load       (pulse_load),
    .load_value (PULSE_LOAD),
    .dec        (pulse_dec),
    .terminal   (pulse_terminal)
  );

  always_comb begin
    state_next        = state_reg;
    adc_rst_sync_next = adc_rst_sync_reg;
    sync_status_next  = sync_status_reg;
    data_enable_next  = data_enable_reg;
    timeout_next      = timeout_reg;
    sync_count_next   = sync_count_reg;
    timeout_load      = 1'b0;
    timeout_dec       = 1'b0;
    pulse_load        = 1'b0;
    pulse_dec         = 1'b0;

    case (state_reg)
      IDLE: begin
        // soft_sync outranks a simultaneous arm and bypasses the timeout.
        if (soft_sync) begin
          state_next       = WAIT_SOF;
          data_enable_next = 1'b0;
          sync_status_next = 1'b1;
        end else if (arm) begin
          state_next       = ARMED;
          data_enable_next = 1'b0;
          sync_status_next = 1'b1;
          timeout_next     = 1'b0;
          timeout_load     = 1'b1;
        end
      end

      ARMED: begin
        timeout_dec = TIMEOUT_EN;
        if (disarm) begin
          state_next       = IDLE;
          data_enable_next = 1'b1;
          sync_status_next = 1'b0;
        end else if (trigger) begin
          state_next = WAIT_SOF;
        end else if (TIMEOUT_EN && timeout_terminal) begin
          state_next       = IDLE;
          timeout_next     = 1'b1;
          data_enable_next = 1'b1;
          sync_status_next = 1'b0;
        end
      end

      WAIT_SOF: begin
        if (disarm) begin
          state_next       = IDLE;
          data_enable_next = 1'b1;
          sync_status_next = 1'b0;
        end else if (sof_beat) begin
          state_next        = PULSE;
          adc_rst_sync_next = 1'b1;
          pulse_load        = 1'b1;
        end
      end

      PULSE: begin
        // Every request input is deliberately ignored until the pulse ends.
        pulse_dec = 1'b1;
        if (pulse_terminal) begin
          state_next        = IDLE;
          adc_rst_sync_next = 1'b0;
          sync_status_next  = 1'b0;
          data_enable_next  = 1'b1;
          sync_count_next   = sync_count_reg + SYNC_COUNT_WIDTH'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= IDLE;
      sync_in_d_reg    <= 1'b0;
      adc_rst_sync_reg <= 1'b0;
      sync_status_reg  <= 1'b0;
      data_enable_reg  <= 1'b1;
      timeout_reg      <= 1'b0;
      sync_count_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      sync_in_d_reg    <= sync_in;
      adc_rst_sync_reg <= adc_rst_sync_next;
      sync_status_reg  <= sync_status_next;
      data_enable_reg  <= data_enable_next;
      timeout_reg      <= timeout_next;
      sync_count_reg   <= sync_count_next;
    end
  end

  assign adc_rst_sync = adc_rst_sync_reg;
  assign sync_status  = sync_status_reg;
  assign data_enable  = data_enable_reg;
  assign timeout      = timeout_reg;
  assign sync_count   = sync_count_reg;

endmodule
